// File: rtl/conv_layer_scheduler_if.sv
// Host handshake, engine control and shared layer-memory port of the CNN layer scheduler.
interface conv_layer_scheduler_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 20
);
  logic              ready;
  logic              busy;
  logic              err;

  logic              conv_start;
  logic              conv_done;
  logic              conv_cwr;
  logic [ADDR_W-1:0] conv_caddr_wr;
  logic [DATA_W-1:0] conv_cdata_wr;

  logic              pool_start;
  logic              pool_done;
  logic              pool_crd;
  logic [ADDR_W-1:0] pool_caddr_rd;
  logic              pool_cwr;
  logic [ADDR_W-1:0] pool_caddr_wr;
  logic [DATA_W-1:0] pool_cdata_wr;
  logic [DATA_W-1:0] pool_cdata_rd;

  logic              cwr;
  logic [ADDR_W-1:0] caddr_wr;
  logic [DATA_W-1:0] cdata_wr;
  logic              crd;
  logic [ADDR_W-1:0] caddr_rd;
  logic [2:0]        csel;
  logic [DATA_W-1:0] cdata_rd;

  modport master (
    input  ready, conv_done, conv_cwr, conv_caddr_wr, conv_cdata_wr,
           pool_done, pool_crd, pool_caddr_rd, pool_cwr, pool_caddr_wr, pool_cdata_wr,
           cdata_rd,
    output busy, err, conv_start, pool_start, pool_cdata_rd,
           cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );

  modport slave (
    output ready, conv_done, conv_cwr, conv_caddr_wr, conv_cdata_wr,
           pool_done, pool_crd, pool_caddr_rd, pool_cwr, pool_caddr_wr, pool_cdata_wr,
           cdata_rd,
    input  busy, err, conv_start, pool_start, pool_cdata_rd,
           cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
  );
endinterface

// File: rtl/conv_layer_scheduler.sv
// CNN layer sequencer: conv -> pool -> optional flatten copy, owning the shared memory port.
// Optional L2 flatten stage is built when macro L2_FLATTEN_EN is defined.
module conv_layer_scheduler #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 20,
  parameter logic [2:0]  L0_SEL   = 3'b001,
  parameter logic [2:0]  L1_SEL   = 3'b011,
  parameter logic [2:0]  L2_SEL   = 3'b101,
  parameter int unsigned L1_DEPTH = 1024,
  parameter int unsigned TIMEOUT  = 20000
) (
  input logic                    clk,
  input logic                    reset,
  conv_layer_scheduler_if.master bus
);

  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_C_START,
    S_C_RUN,
    S_P_START,
    S_P_RUN,
`ifdef L2_FLATTEN_EN
    S_F_RD,
    S_F_WR,
`endif
    S_FIN
  } state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              conv_start_q, conv_start_d;
  logic              pool_start_q, pool_start_d;
  logic              cwr_q, cwr_d;
  logic              crd_q, crd_d;
  logic [2:0]        csel_q, csel_d;
  logic [ADDR_W-1:0] caddr_wr_q, caddr_wr_d;
  logic [ADDR_W-1:0] caddr_rd_q, caddr_rd_d;
  logic [DATA_W-1:0] cdata_wr_q, cdata_wr_d;
  logic [WD_W-1:0]   wd_q, wd_d;
`ifdef L2_FLATTEN_EN
  logic [ADDR_W-1:0] k_q, k_d;
`endif

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    err_d        = err_q;
    conv_start_d = 1'b0;
    pool_start_d = 1'b0;
    cwr_d        = 1'b0;
    crd_d        = 1'b0;
    csel_d       = csel_q;
    caddr_wr_d   = caddr_wr_q;
    caddr_rd_d   = caddr_rd_q;
    cdata_wr_d   = cdata_wr_q;
    wd_d         = wd_q;
`ifdef L2_FLATTEN_EN
    k_d          = k_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.ready) begin
          busy_d  = 1'b1;
          state_d = S_C_START;
        end
      end

      S_C_START: begin
        conv_start_d = 1'b1;
        wd_d         = '0;
        state_d      = S_C_RUN;
      end

      S_C_RUN: begin
        cwr_d      = bus.conv_cwr;
        caddr_wr_d = bus.conv_caddr_wr;
        cdata_wr_d = bus.conv_cdata_wr;
        csel_d     = L0_SEL;
        wd_d       = wd_q + WD_W'(1);
        if (bus.conv_done) begin
          state_d = S_P_START;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end

      S_P_START: begin
        pool_start_d = 1'b1;
        wd_d         = '0;
        state_d      = S_P_RUN;
      end

      S_P_RUN: begin
        wd_d = wd_q + WD_W'(1);
        if (bus.pool_crd) begin
          crd_d      = 1'b1;
          caddr_rd_d = bus.pool_caddr_rd;
          csel_d     = L0_SEL;
          if (bus.pool_cwr) err_d = 1'b1;
        end else if (bus.pool_cwr) begin
          cwr_d      = 1'b1;
          caddr_wr_d = bus.pool_caddr_wr;
          cdata_wr_d = bus.pool_cdata_wr;
          csel_d     = L1_SEL;
        end
        if (bus.pool_done) begin
`ifdef L2_FLATTEN_EN
          // First flatten read is issued on the exit edge; a forwarded last pool
          // write also targets L1, so both share csel=L1_SEL without conflict.
          crd_d      = 1'b1;
          caddr_rd_d = '0;
          csel_d     = L1_SEL;
          k_d        = '0;
          state_d    = S_F_RD;
`else
          state_d    = S_FIN;
`endif
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end
      end

`ifdef L2_FLATTEN_EN
      S_F_RD: begin
        cwr_d      = 1'b1;
        csel_d     = L2_SEL;
        caddr_wr_d = k_q;
        cdata_wr_d = bus.cdata_rd;
        state_d    = S_F_WR;
      end

      S_F_WR: begin
        if (k_q == ADDR_W'(L1_DEPTH - 1)) begin
          state_d = S_FIN;
        end else begin
          k_d        = k_q + ADDR_W'(1);
          crd_d      = 1'b1;
          caddr_rd_d = k_q + ADDR_W'(1);
          csel_d     = L1_SEL;
          state_d    = S_F_RD;
        end
      end
`endif

      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      conv_start_q <= 1'b0;
      pool_start_q <= 1'b0;
      cwr_q        <= 1'b0;
      crd_q        <= 1'b0;
      csel_q       <= '0;
      caddr_wr_q   <= '0;
      caddr_rd_q   <= '0;
      cdata_wr_q   <= '0;
      wd_q         <= '0;
`ifdef L2_FLATTEN_EN
      k_q          <= '0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      conv_start_q <= conv_start_d;
      pool_start_q <= pool_start_d;
      cwr_q        <= cwr_d;
      crd_q        <= crd_d;
      csel_q       <= csel_d;
      caddr_wr_q   <= caddr_wr_d;
      caddr_rd_q   <= caddr_rd_d;
      cdata_wr_q   <= cdata_wr_d;
      wd_q         <= wd_d;
`ifdef L2_FLATTEN_EN
      k_q          <= k_d;
`endif
    end
  end

  assign bus.busy          = busy_q;
  assign bus.err           = err_q;
  assign bus.conv_start    = conv_start_q;
  assign bus.pool_start    = pool_start_q;
  assign bus.cwr           = cwr_q;
  assign bus.crd           = crd_q;
  assign bus.csel          = csel_q;
  assign bus.caddr_wr      = caddr_wr_q;
  assign bus.caddr_rd      = caddr_rd_q;
  assign bus.cdata_wr      = cdata_wr_q;
  assign bus.pool_cdata_rd = bus.cdata_rd;

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler; small TIMEOUT/L1_DEPTH keep runs short.
module tb_conv_layer_scheduler;

  localparam int TB_TIMEOUT = 40;
  localparam int TB_DEPTH   = 8;
`ifdef L2_FLATTEN_EN
  localparam int FLAT_CYC = 2 * TB_DEPTH;
`else
  localparam int FLAT_CYC = 0;
`endif
  localparam int RUN_LEN = 1 + FLAT_CYC;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  conv_layer_scheduler_if #(.ADDR_W(12), .DATA_W(20)) bus ();

  conv_layer_scheduler #(
    .ADDR_W  (12),
    .DATA_W  (20),
    .L1_DEPTH(TB_DEPTH),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  // Layer memories: L1 is read combinationally, L1/L2 written on the registered port.
  logic [19:0] l1_mem [0:7] = '{20'h00000, 20'h11111, 20'h22222, 20'h33333,
                                20'h00000, 20'h0ABCD, 20'h66666, 20'h00000};
  logic [19:0] l2_mem [0:7] = '{default: 20'h00000};

  always_comb begin
    bus.cdata_rd = 20'h00000;
    if (bus.crd && bus.csel == 3'b011) bus.cdata_rd = l1_mem[bus.caddr_rd[2:0]];
  end

  always @(posedge clk) begin
    if (bus.cwr && bus.csel == 3'b011) l1_mem[bus.caddr_wr[2:0]] <= bus.cdata_wr;
    if (bus.cwr && bus.csel == 3'b101) l2_mem[bus.caddr_wr[2:0]] <= bus.cdata_wr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    logic seen_ps;

    reset             = 1'b1;
    bus.ready         = 1'b0;
    bus.conv_done     = 1'b0;
    bus.conv_cwr      = 1'b0;
    bus.conv_caddr_wr = '0;
    bus.conv_cdata_wr = '0;
    bus.pool_done     = 1'b0;
    bus.pool_crd      = 1'b0;
    bus.pool_caddr_rd = '0;
    bus.pool_cwr      = 1'b0;
    bus.pool_caddr_wr = '0;
    bus.pool_cdata_wr = '0;
    repeat (2) tick();

    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_cwr", 32'(bus.cwr), 0);
    chk("rst_crd", 32'(bus.crd), 0);
    chk("rst_csel", 32'(bus.csel), 0);
    chk("rst_conv_start", 32'(bus.conv_start), 0);
    chk("rst_pool_start", 32'(bus.pool_start), 0);
    chk("rst_caddr_wr", 32'(bus.caddr_wr), 0);
    chk("rst_cdata_wr", 32'(bus.cdata_wr), 0);
    chk("rst_caddr_rd", 32'(bus.caddr_rd), 0);
    reset = 1'b0;
    tick();

    // Run start and conv_start pulse
    bus.ready = 1'b1;
    tick();
    chk("busy_rise", 32'(bus.busy), 1);
    chk("conv_start_early", 32'(bus.conv_start), 0);
    bus.ready = 1'b0;
    tick();
    chk("conv_start_pulse", 32'(bus.conv_start), 1);
    tick();
    chk("conv_start_single", 32'(bus.conv_start), 0);

    // Conv write forwarded one cycle later on L0
    bus.conv_cwr      = 1'b1;
    bus.conv_caddr_wr = 12'h0A5;
    bus.conv_cdata_wr = 20'h01234;
    tick();
    chk("conv_cwr", 32'(bus.cwr), 1);
    chk("conv_caddr_wr", 32'(bus.caddr_wr), 32'h0A5);
    chk("conv_cdata_wr", 32'(bus.cdata_wr), 32'h01234);
    chk("conv_csel", 32'(bus.csel), 32'h1);
    chk("conv_crd", 32'(bus.crd), 0);
    bus.conv_cwr = 1'b0;
    tick();
    chk("conv_cwr_off", 32'(bus.cwr), 0);

    // pool_start two edges after conv_done
    bus.conv_done = 1'b1;
    tick();
    chk("pool_start_edge1", 32'(bus.pool_start), 0);
    bus.conv_done = 1'b0;
    tick();
    chk("pool_start_edge2", 32'(bus.pool_start), 1);
    tick();
    chk("pool_start_single", 32'(bus.pool_start), 0);

    // Pool read then write
    bus.pool_crd      = 1'b1;
    bus.pool_caddr_rd = 12'h010;
    tick();
    chk("pool_crd", 32'(bus.crd), 1);
    chk("pool_caddr_rd", 32'(bus.caddr_rd), 32'h010);
    chk("pool_rd_csel", 32'(bus.csel), 32'h1);
    chk("pool_rd_cwr", 32'(bus.cwr), 0);
    bus.pool_crd      = 1'b0;
    bus.pool_cwr      = 1'b1;
    bus.pool_caddr_wr = 12'h004;
    bus.pool_cdata_wr = 20'h5A5A5;
    tick();
    chk("pool_cwr", 32'(bus.cwr), 1);
    chk("pool_caddr_wr", 32'(bus.caddr_wr), 32'h004);
    chk("pool_cdata_wr", 32'(bus.cdata_wr), 32'h5A5A5);
    chk("pool_wr_csel", 32'(bus.csel), 32'h3);
    chk("pool_wr_crd", 32'(bus.crd), 0);

    // Idle pool cycle: csel holds, inactive conv strobe ignored
    bus.pool_cwr = 1'b0;
    bus.conv_cwr = 1'b1;
    tick();
    chk("hold_csel", 32'(bus.csel), 32'h3);
    chk("inactive_conv_cwr", 32'(bus.cwr), 0);
    chk("err_before_clash", 32'(bus.err), 0);
    bus.conv_cwr = 1'b0;

    // Both strobes: read wins, err set
    bus.pool_crd      = 1'b1;
    bus.pool_cwr      = 1'b1;
    bus.pool_caddr_rd = 12'h020;
    bus.pool_caddr_wr = 12'h030;
    tick();
    chk("clash_crd", 32'(bus.crd), 1);
    chk("clash_cwr", 32'(bus.cwr), 0);
    chk("clash_caddr_rd", 32'(bus.caddr_rd), 32'h020);
    chk("clash_csel", 32'(bus.csel), 32'h1);
    chk("clash_err", 32'(bus.err), 1);

    // Write coinciding with pool_done still forwarded
    bus.pool_crd      = 1'b0;
    bus.pool_cwr      = 1'b1;
    bus.pool_done     = 1'b1;
    bus.pool_caddr_wr = 12'h007;
    bus.pool_cdata_wr = 20'h00077;
    tick();
    chk("done_cwr", 32'(bus.cwr), 1);
    chk("done_caddr_wr", 32'(bus.caddr_wr), 32'h007);
    chk("done_cdata_wr", 32'(bus.cdata_wr), 32'h00077);
    chk("done_busy", 32'(bus.busy), 1);
    bus.pool_cwr  = 1'b0;
    bus.pool_done = 1'b0;

    n = 0;
    while (bus.busy && n < 200) begin
      tick();
      n++;
    end
    chk("run_len", 32'(n), 32'(RUN_LEN));
    chk("end_busy", 32'(bus.busy), 0);
    chk("end_cwr", 32'(bus.cwr), 0);
    chk("end_crd", 32'(bus.crd), 0);
    chk("err_sticky", 32'(bus.err), 1);
`ifdef L2_FLATTEN_EN
    chk("l2_0", 32'(l2_mem[0]), 32'h00000);
    chk("l2_4", 32'(l2_mem[4]), 32'h5A5A5);
    chk("l2_5", 32'(l2_mem[5]), 32'h0ABCD);
    chk("l2_7", 32'(l2_mem[7]), 32'h00077);
`endif

    // Reset during P_RUN
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    tick();
    bus.conv_done = 1'b1;
    tick();
    bus.conv_done = 1'b0;
    tick();
    bus.pool_cwr      = 1'b1;
    bus.pool_caddr_wr = 12'h001;
    tick();
    chk("prerst_cwr", 32'(bus.cwr), 1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_cwr", 32'(bus.cwr), 0);
    chk("midrst_csel", 32'(bus.csel), 0);
    chk("midrst_err", 32'(bus.err), 0);
    chk("midrst_caddr_wr", 32'(bus.caddr_wr), 0);
    bus.pool_cwr = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Restart from C_START, then conv watchdog timeout
    bus.ready = 1'b1;
    tick();
    chk("restart_busy", 32'(bus.busy), 1);
    bus.ready = 1'b0;
    tick();
    chk("restart_conv_start", 32'(bus.conv_start), 1);
    seen_ps = 1'b0;
    for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
      bus.ready = (i == 5 || i == 6);
      tick();
      seen_ps = seen_ps | bus.pool_start;
    end
    bus.ready = 1'b0;
    chk("to_err_before", 32'(bus.err), 0);
    chk("to_busy_before", 32'(bus.busy), 1);
    tick();
    chk("to_err", 32'(bus.err), 1);
    tick();
    chk("to_busy_fall", 32'(bus.busy), 0);
    repeat (3) begin
      tick();
      seen_ps = seen_ps | bus.pool_start;
    end
    chk("to_no_pool_start", 32'(seen_ps), 0);
    chk("to_err_sticky", 32'(bus.err), 1);
    chk("to_idle_busy", 32'(bus.busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
